stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
- Initiator-side sequencer for the processor's hardware return stack; it owns the stack's c/en/push inputs and consumes its peek/full/not_empty outputs.
- Turns single-cycle CALL and RET requests from the control unit into correctly ordered push/pop operations on the stack.
- Delivers the new program-counter value to the PC register with a one-cycle load strobe.
- Keeps a shadow occupancy count and sticky overflow/underflow flags for debug and trap logic.

Parameters:
- width, 8, data/address width; matches the stack's width.
- depth, 1, log2 of stack entry count; the stack holds 2**depth entries.

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  asynchronous, active-low reset (0 = reset).
- call  input  1  CALL request, sampled when busy=0.
- ret  input  1  RET request, sampled when busy=0.
- target  input  width  CALL destination address.
- ret_addr  input  width  return address to save on CALL (PC+1, computed upstream).
- busy  output  1  high while a request is in flight; new requests are ignored.
- pc_load  output  1  one-cycle strobe; PC register loads pc_out.
- pc_out  output  width  next PC value.
- done  output  1  one-cycle completion pulse for every accepted request, including faulted ones.
- err_ovf  output  1  sticky: a CALL was attempted while the stack was full.
- err_unf  output  1  sticky: a RET was attempted while the stack was empty.
- err_clr  input  1  synchronous clear of err_ovf and err_unf.
- level  output  depth+1  shadow count of entries, 0..2**depth.
- stk_c  output  1  to stack c: 1 = push, 0 = pop.
- stk_en  output  1  to stack en.
- stk_push  output  width  to stack push data.
- stk_peek  input  width  from stack peek (top of stack).
- stk_full  input  1  from stack full.
- stk_not_empty  input  1  from stack not_empty.

Behaviour:
- All outputs are registered.
- Reset (clr=0), asynchronous: state=IDLE; busy, pc_load, done, stk_en, stk_c, err_ovf, err_unf = 0; pc_out, stk_push, level = 0.
- Reset mid-operation aborts the request immediately; stk_en drops without waiting for a clock.
- States: IDLE, PUSH, POP, FIN.
- IDLE, call=1 (call has priority if call and ret are both high):
  - stk_full=0: latch target into pc_out; stk_push<=ret_addr; stk_en<=1; stk_c<=1; busy<=1; go to PUSH.
  - stk_full=1: set err_ovf; busy<=1; no stack access; go to FIN with pc_load suppressed.
- IDLE, ret=1 and call=0:
  - stk_not_empty=1: latch stk_peek into pc_out in the same cycle as acceptance; stk_en<=1; stk_c<=0; busy<=1; go to POP.
  - stk_not_empty=0: set err_unf; go to FIN with pc_load suppressed.
- PUSH: stk_en<=0; level<=level+1; go to FIN.
- POP: stk_en<=0; level<=level-1; go to FIN.
- stk_en is high for exactly one cycle per accepted non-faulted request.
- FIN:
  - pc_load<=1 unless faulted; done<=1; busy<=0; go to IDLE.
  - pc_load and done fall the following cycle.
- Latency: request sampled at edge N; stack operates at edge N+1; pc_load/done high from N+2 to N+3. Back-to-back requests are accepted at edge N+3 at the earliest.
- level saturates: never above 2**depth, never below 0. If a faulted request would move level out of range, level holds.
- err_clr=1 clears both flags. If a fault and err_clr occur in the same cycle, the fault wins and the flag stays set.
- call/ret while busy=1 are ignored entirely: no flag change, no queueing.
- pc_out holds its last value between requests.

Test Plan:
- Reset: clr=0 mid-PUSH, asynchronously, with no clock edge -> stk_en=0, busy=0, level=0, errs=0 immediately.
- CALL with target=0x40, ret_addr=0x11 on an empty stack -> stk_en=1, stk_c=1, stk_push=0x11 for one cycle; pc_load=1 with pc_out=0x40 two cycles after acceptance; level=1.
- RET after that CALL -> pc_out=0x11, pc_load pulse, one-cycle pop (stk_en=1, stk_c=0); level=0, stk_not_empty=0.
- depth=1: two CALLs succeed (level=2, stk_full=1); third CALL -> err_ovf=1, done pulses, no pc_load, no stk_en, level stays 2.
- RET on an empty stack -> err_unf=1, done without pc_load. err_clr=1 next cycle -> err_unf=0. err_clr concurrent with a new fault -> flag remains 1.
- call=ret=1 together -> CALL behaviour only. A second call asserted while busy -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences CALL/RET requests into push/pop operations on the
// hardware return stack, loads the PC with the new target or return address,
// and keeps a shadow occupancy count plus sticky overflow/underflow flags.
module stack_ctrl #(
   parameter int width = 8,
   parameter int depth = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             call,
   input  logic             ret,
   input  logic [width-1:0] target,
   input  logic [width-1:0] ret_addr,
   output logic             busy,
   output logic             pc_load,
   output logic [width-1:0] pc_out,
   output logic             done,
   output logic             err_ovf,
   output logic             err_unf,
   input  logic             err_clr,
   output logic [depth:0]   level,
   output logic             stk_c,
   output logic             stk_en,
   output logic [width-1:0] stk_push,
   input  logic [width-1:0] stk_peek,
   input  logic             stk_full,
   input  logic             stk_not_empty
);

   typedef enum logic [1:0] {
      IDLE,
      PUSH,
      POP,
      FIN
   } state_t;

   localparam int unsigned  LVL_MAX_I = 2 ** depth;
   localparam logic [depth:0] LVL_MAX = LVL_MAX_I[depth:0];

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               pc_load_q, pc_load_d;
   logic [width-1:0]   pc_out_q, pc_out_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic [depth:0]     level_q, level_d;
   logic               stk_c_q, stk_c_d;
   logic               stk_en_q, stk_en_d;
   logic [width-1:0]   stk_push_q, stk_push_d;
   // remembers that the request in flight faulted, so FIN skips pc_load
   logic               fault_q, fault_d;
   logic               ovf_set, unf_set;

   // next-state, datapath and flag logic; requests are only looked at in IDLE
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      pc_load_d  = 1'b0;
      done_d     = 1'b0;
      pc_out_d   = pc_out_q;
      level_d    = level_q;
      stk_c_d    = stk_c_q;
      stk_en_d   = stk_en_q;
      stk_push_d = stk_push_q;
      fault_d    = fault_q;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;

      case (state_q)
         IDLE: begin
            if (call) begin
               busy_d = 1'b1;
               if (!stk_full) begin
                  pc_out_d   = target;
                  stk_push_d = ret_addr;
                  stk_en_d   = 1'b1;
                  stk_c_d    = 1'b1;
                  fault_d    = 1'b0;
                  state_d    = PUSH;
               end else begin
                  ovf_set = 1'b1;
                  fault_d = 1'b1;
                  state_d = FIN;
               end
            end else if (ret) begin
               busy_d = 1'b1;
               if (stk_not_empty) begin
                  pc_out_d = stk_peek;
                  stk_en_d = 1'b1;
                  stk_c_d  = 1'b0;
                  fault_d  = 1'b0;
                  state_d  = POP;
               end else begin
                  unf_set = 1'b1;
                  fault_d = 1'b1;
                  state_d = FIN;
               end
            end
         end
         PUSH: begin
            stk_en_d = 1'b0;
            if (level_q != LVL_MAX) begin
               level_d = level_q + 1'b1;
            end
            state_d = FIN;
         end
         POP: begin
            stk_en_d = 1'b0;
            if (level_q != '0) begin
               level_d = level_q - 1'b1;
            end
            state_d = FIN;
         end
         FIN: begin
            pc_load_d = ~fault_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // a fault in the same cycle as err_clr keeps the flag set
      ovf_d = ovf_set | (ovf_q & ~err_clr);
      unf_d = unf_set | (unf_q & ~err_clr);
   end

   // state and output registers; clr aborts any request without a clock
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         pc_load_q  <= 1'b0;
         pc_out_q   <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         level_q    <= '0;
         stk_c_q    <= 1'b0;
         stk_en_q   <= 1'b0;
         stk_push_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         pc_load_q  <= pc_load_d;
         pc_out_q   <= pc_out_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         level_q    <= level_d;
         stk_c_q    <= stk_c_d;
         stk_en_q   <= stk_en_d;
         stk_push_q <= stk_push_d;
         fault_q    <= fault_d;
      end
   end

   assign busy     = busy_q;
   assign pc_load  = pc_load_q;
   assign pc_out   = pc_out_q;
   assign done     = done_q;
   assign err_ovf  = ovf_q;
   assign err_unf  = unf_q;
   assign level    = level_q;
   assign stk_c    = stk_c_q;
   assign stk_en   = stk_en_q;
   assign stk_push = stk_push_q;

endmodule
